// File: rtl/host_load_ctrl.sv
// host_load_ctrl: routes host bytes from ui_in into instruction memory, weight
// memory or the unified buffer with auto-incrementing addresses, and gates the
// external start pin so the control unit only launches while no load is active.
module host_load_ctrl #(
    parameter int ADDR_W    = 13,
    parameter int INS_DEPTH = 16,
    parameter int W_DEPTH   = 4,
    parameter int UB_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        ui_in,
    input  logic              fetch_ins,
    input  logic              fetch_w,
    input  logic              fetch_inp,
    input  logic              start,
    input  logic              cu_done,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en_ins,
    output logic              wr_en_w,
    output logic              wr_en_ub,
    output logic [4:0]        ins_len,
    output logic              start_cu,
    output logic              busy,
    output logic              ovf,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        LD_INS,
        LD_W,
        LD_INP,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] INS_LIM = ADDR_W'(INS_DEPTH);
    localparam logic [ADDR_W-1:0] W_LIM   = ADDR_W'(W_DEPTH);
    localparam logic [ADDR_W-1:0] UB_LIM  = ADDR_W'(UB_DEPTH);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic              start_q;
    logic              start_rise;
    logic              any_fetch;

    // per-cycle decisions produced by the output decode
    logic              cap_ins;
    logic              cap_w;
    logic              cap_inp;
    logic [ADDR_W-1:0] cnt_base;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] depth_lim;
    logic              we_ins_d;
    logic              we_w_d;
    logic              we_ub_d;
    logic              start_d;
    logic              ovf_set;
    logic              err_set;
    logic              ins_len_load;
    logic [4:0]        ins_len_d;

    assign start_rise = start & ~start_q;
    assign any_fetch  = fetch_ins | fetch_w | fetch_inp;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state selection; fetch priority ins > w > inp, loads beat start
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (fetch_ins)       state_next = LD_INS;
                else if (fetch_w)    state_next = LD_W;
                else if (fetch_inp)  state_next = LD_INP;
                else if (start_rise) state_next = RUN;
            end
            LD_INS:  if (!fetch_ins) state_next = IDLE;
            LD_W:    if (!fetch_w)   state_next = IDLE;
            LD_INP:  if (!fetch_inp) state_next = IDLE;
            RUN:     if (cu_done)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // output decode: which target captures this cycle, counter update, flags
    always_comb begin
        cap_ins      = 1'b0;
        cap_w        = 1'b0;
        cap_inp      = 1'b0;
        cnt_base     = cnt;
        start_d      = 1'b0;
        err_set      = 1'b0;
        ins_len_load = 1'b0;
        busy         = (state != IDLE);

        unique case (state)
            IDLE: begin
                // the entry-cycle byte is byte 0, so the base is forced to 0 here
                cnt_base = '0;
                if (fetch_ins)       cap_ins = 1'b1;
                else if (fetch_w)    cap_w   = 1'b1;
                else if (fetch_inp)  cap_inp = 1'b1;
                else if (start_rise) start_d = 1'b1;
                if (any_fetch && start_rise) err_set = 1'b1;
            end
            LD_INS: begin
                if (fetch_ins) cap_ins = 1'b1;
                else           ins_len_load = 1'b1;
                if (start_rise) err_set = 1'b1;
            end
            LD_W: begin
                if (fetch_w) cap_w = 1'b1;
                if (start_rise) err_set = 1'b1;
            end
            LD_INP: begin
                if (fetch_inp) cap_inp = 1'b1;
                if (start_rise) err_set = 1'b1;
            end
            RUN: begin
                if (any_fetch) err_set = 1'b1;
            end
            default: ;
        endcase

        depth_lim = cap_ins ? INS_LIM : (cap_w ? W_LIM : UB_LIM);

        we_ins_d = 1'b0;
        we_w_d   = 1'b0;
        we_ub_d  = 1'b0;
        ovf_set  = 1'b0;
        cnt_d    = cnt_base;
        if (cap_ins || cap_w || cap_inp) begin
            if (cnt_base == depth_lim) begin
                ovf_set = 1'b1;
            end else begin
                we_ins_d = cap_ins;
                we_w_d   = cap_w;
                we_ub_d  = cap_inp;
                cnt_d    = cnt_base + ADDR_W'(1);
            end
        end

        ins_len_d = (cnt > INS_LIM) ? 5'(INS_DEPTH) : cnt[4:0];
    end

    // registered datapath: one-cycle write latency, sticky flags, start pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            start_q   <= 1'b0;
            wr_data   <= '0;
            wr_addr   <= '0;
            wr_en_ins <= 1'b0;
            wr_en_w   <= 1'b0;
            wr_en_ub  <= 1'b0;
            ins_len   <= '0;
            start_cu  <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            start_q   <= start;
            wr_en_ins <= we_ins_d;
            wr_en_w   <= we_w_d;
            wr_en_ub  <= we_ub_d;
            start_cu  <= start_d;
            if (we_ins_d || we_w_d || we_ub_d) begin
                wr_data <= ui_in;
                wr_addr <= cnt_base;
            end
            if (ins_len_load) ins_len <= ins_len_d;
            if (ovf_set)      ovf <= 1'b1;
            if (err_set)      err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_host_load_ctrl.sv
// tb_host_load_ctrl: directed cycle-by-cycle bench for host_load_ctrl.
module tb_host_load_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ui_in;
    logic        fetch_ins;
    logic        fetch_w;
    logic        fetch_inp;
    logic        start;
    logic        cu_done;
    logic [7:0]  wr_data;
    logic [12:0] wr_addr;
    logic        wr_en_ins;
    logic        wr_en_w;
    logic        wr_en_ub;
    logic [4:0]  ins_len;
    logic        start_cu;
    logic        busy;
    logic        ovf;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_writes;

    host_load_ctrl #(
        .ADDR_W   (13),
        .INS_DEPTH(16),
        .W_DEPTH  (4),
        .UB_DEPTH (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ui_in    (ui_in),
        .fetch_ins(fetch_ins),
        .fetch_w  (fetch_w),
        .fetch_inp(fetch_inp),
        .start    (start),
        .cu_done  (cu_done),
        .wr_data  (wr_data),
        .wr_addr  (wr_addr),
        .wr_en_ins(wr_en_ins),
        .wr_en_w  (wr_en_w),
        .wr_en_ub (wr_en_ub),
        .ins_len  (ins_len),
        .start_cu (start_cu),
        .busy     (busy),
        .ovf      (ovf),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; ui_in = '0; fetch_ins = 0; fetch_w = 0; fetch_inp = 0;
        start = 0; cu_done = 0;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_wr_en"}, {13'd0, wr_en_ins, wr_en_w, wr_en_ub}, 16'd0);
        check({tag, "_busy"}, {15'd0, busy}, 16'd0);
        check({tag, "_start_cu"}, {15'd0, start_cu}, 16'd0);
    endtask

    initial begin
        logic [7:0] wdat [4];
        wdat[0] = 8'd11; wdat[1] = 8'd22; wdat[2] = 8'd33; wdat[3] = 8'd44;

        // reset state
        do_reset();
        check_idle_zero("rst");
        check("rst_addr", {3'd0, wr_addr}, 16'd0);
        check("rst_data", {8'd0, wr_data}, 16'd0);
        check("rst_flags", {13'd0, ovf, err, 1'b0}, 16'd0);
        check("rst_ins_len", {11'd0, ins_len}, 16'd0);

        // 1: four weight bytes
        for (int i = 0; i < 4; i++) begin
            fetch_w = 1; ui_in = wdat[i];
            tick();
            check("t1_en", {13'd0, wr_en_ins, wr_en_w, wr_en_ub}, 16'b010);
            check("t1_addr", {3'd0, wr_addr}, 16'(i));
            check("t1_data", {8'd0, wr_data}, {8'd0, wdat[i]});
            check("t1_busy", {15'd0, busy}, 16'd1);
        end
        fetch_w = 0;
        tick();
        check_idle_zero("t1_end");

        // 2: six instruction bytes
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fetch_ins = 1; ui_in = 8'h40 + 8'(i);
            tick();
            check("t2_en", {13'd0, wr_en_ins, wr_en_w, wr_en_ub}, 16'b100);
            check("t2_addr", {3'd0, wr_addr}, 16'(i));
            check("t2_data", {8'd0, wr_data}, 16'h40 + 16'(i));
        end
        fetch_ins = 0;
        tick();
        check_idle_zero("t2_end");
        check("t2_ins_len", {11'd0, ins_len}, 16'd6);

        // 3: six weight bytes against depth 4
        do_reset();
        n_writes = 0;
        for (int i = 0; i < 6; i++) begin
            fetch_w = 1; ui_in = 8'h70 + 8'(i);
            tick();
            if (wr_en_w) n_writes++;
            check("t3_ovf", {15'd0, ovf}, (i >= 4) ? 16'd1 : 16'd0);
            check("t3_addr", {3'd0, wr_addr}, (i >= 4) ? 16'd3 : 16'(i));
            check("t3_en", {15'd0, wr_en_w}, (i >= 4) ? 16'd0 : 16'd1);
        end
        fetch_w = 0;
        tick();
        if (wr_en_w) n_writes++;
        check("t3_writes", 16'(n_writes), 16'd4);
        check("t3_busy", {15'd0, busy}, 16'd0);
        check("t3_ovf_sticky", {15'd0, ovf}, 16'd1);

        // 4: fetch_ins and fetch_inp together
        do_reset();
        fetch_inp = 1;
        for (int i = 0; i < 3; i++) begin
            fetch_ins = 1; ui_in = 8'hA0 + 8'(i);
            tick();
            check("t4_ins_en", {13'd0, wr_en_ins, wr_en_w, wr_en_ub}, 16'b100);
            check("t4_ins_addr", {3'd0, wr_addr}, 16'(i));
        end
        fetch_ins = 0; ui_in = 8'hB0;
        tick();
        check_idle_zero("t4_gap");
        check("t4_ins_len", {11'd0, ins_len}, 16'd3);
        for (int i = 0; i < 2; i++) begin
            ui_in = 8'hB1 + 8'(i);
            tick();
            check("t4_ub_en", {13'd0, wr_en_ins, wr_en_w, wr_en_ub}, 16'b001);
            check("t4_ub_addr", {3'd0, wr_addr}, 16'(i));
            check("t4_ub_data", {8'd0, wr_data}, 16'hB1 + 16'(i));
        end
        fetch_inp = 0;
        tick();
        check_idle_zero("t4_end");
        check("t4_err", {15'd0, err}, 16'd0);

        // 5: start in IDLE, fetch during RUN, cu_done back to IDLE
        do_reset();
        start = 1;
        tick();
        check("t5_start_cu", {15'd0, start_cu}, 16'd1);
        check("t5_busy", {15'd0, busy}, 16'd1);
        fetch_inp = 1; ui_in = 8'h55;
        tick();
        check("t5_start_once", {15'd0, start_cu}, 16'd0);
        check("t5_no_wr", {13'd0, wr_en_ins, wr_en_w, wr_en_ub}, 16'd0);
        check("t5_err", {15'd0, err}, 16'd1);
        tick();
        check("t5_no_wr2", {13'd0, wr_en_ins, wr_en_w, wr_en_ub}, 16'd0);
        check("t5_run_busy", {15'd0, busy}, 16'd1);
        fetch_inp = 0; cu_done = 1;
        tick();
        cu_done = 0; start = 0;
        check_idle_zero("t5_done");
        check("t5_err_sticky", {15'd0, err}, 16'd1);

        // 6: reset on the third byte of an input load
        do_reset();
        fetch_inp = 1; ui_in = 8'hC0;
        tick();
        check("t6_b0", {3'd0, wr_addr}, 16'd0);
        ui_in = 8'hC1; start = 1;
        tick();
        check("t6_b1", {3'd0, wr_addr}, 16'd1);
        check("t6_err_load", {15'd0, err}, 16'd1);
        ui_in = 8'hC2; reset = 1; start = 0;
        tick();
        reset = 0;
        check_idle_zero("t6_rst");
        check("t6_addr", {3'd0, wr_addr}, 16'd0);
        check("t6_data", {8'd0, wr_data}, 16'd0);
        check("t6_flags", {14'd0, ovf, err}, 16'd0);
        ui_in = 8'hD0;
        tick();
        check("t6_restart_en", {13'd0, wr_en_ins, wr_en_w, wr_en_ub}, 16'b001);
        check("t6_restart_addr", {3'd0, wr_addr}, 16'd0);
        check("t6_restart_data", {8'd0, wr_data}, 16'hD0);
        fetch_inp = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
